// File: rtl/dual_port_ram_arbiter.sv
// Two-master front end for a single dual_port_ram: independent round-robin
// arbiters on the write and read ports, plus same-cycle write-to-read forwarding.

module dual_port_ram_arbiter_rr2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] ack,
    output logic       grant_valid,
    output logic       grant_idx
);
    logic       last_grant_reg;
    logic [1:0] eligible;

    // A master in its ack cycle still shows the old request; ignore it.
    assign eligible = req & ~ack;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        case (eligible)
            2'b01: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end
            2'b10: begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
            2'b11: begin
                grant_valid = 1'b1;
                grant_idx   = ~last_grant_reg;
            end
            default: begin
                grant_valid = 1'b0;
                grant_idx   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg <= 1'b1;
        end else if (grant_valid) begin
            last_grant_reg <= grant_idx;
        end
    end
endmodule

module dual_port_ram_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  m0_wr_req,
    input  logic                  m1_wr_req,
    input  logic [ADDR_WIDTH-1:0] m0_waddr,
    input  logic [ADDR_WIDTH-1:0] m1_waddr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m0_wr_ack,
    output logic                  m1_wr_ack,
    input  logic                  m0_rd_req,
    input  logic                  m1_rd_req,
    input  logic [ADDR_WIDTH-1:0] m0_raddr,
    input  logic [ADDR_WIDTH-1:0] m1_raddr,
    output logic                  m0_rd_ack,
    output logic                  m1_rd_ack,
    output logic                  m0_rd_valid,
    output logic                  m1_rd_valid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    input  logic [DATA_WIDTH-1:0] ram_dout
);
    logic [ADDR_WIDTH-1:0] waddr_arr [2];
    logic [DATA_WIDTH-1:0] wdata_arr [2];
    logic [ADDR_WIDTH-1:0] raddr_arr [2];

    logic [1:0] wr_req_vec;
    logic [1:0] rd_req_vec;
    logic [1:0] wr_ack_reg;
    logic [1:0] rd_ack_reg;
    logic [1:0] rd_valid_reg;
    logic [1:0] wr_ack_next;
    logic [1:0] rd_ack_next;

    logic w_grant_valid;
    logic w_grant_idx;
    logic r_grant_valid;
    logic r_grant_idx;

    logic                  ram_write_en_reg;
    logic [ADDR_WIDTH-1:0] ram_waddr_reg;
    logic [DATA_WIDTH-1:0] ram_din_reg;
    logic [ADDR_WIDTH-1:0] ram_raddr_reg;

    logic                  fwd_hit_reg;
    logic                  fwd_hit_next;
    logic [DATA_WIDTH-1:0] fwd_data_reg;
    logic [DATA_WIDTH-1:0] rdata_mux;

    assign waddr_arr[0] = m0_waddr;
    assign waddr_arr[1] = m1_waddr;
    assign wdata_arr[0] = m0_wdata;
    assign wdata_arr[1] = m1_wdata;
    assign raddr_arr[0] = m0_raddr;
    assign raddr_arr[1] = m1_raddr;
    assign wr_req_vec   = {m1_wr_req, m0_wr_req};
    assign rd_req_vec   = {m1_rd_req, m0_rd_req};

    dual_port_ram_arbiter_rr2 u_warb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (wr_req_vec),
        .ack         (wr_ack_reg),
        .grant_valid (w_grant_valid),
        .grant_idx   (w_grant_idx)
    );

    dual_port_ram_arbiter_rr2 u_rarb (
        .clk         (clk),
        .reset_n     (reset_n),
        .req         (rd_req_vec),
        .ack         (rd_ack_reg),
        .grant_valid (r_grant_valid),
        .grant_idx   (r_grant_idx)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign wr_ack_next[gi] = w_grant_valid & (w_grant_idx == 1'(gi));
            assign rd_ack_next[gi] = r_grant_valid & (r_grant_idx == 1'(gi));
        end
    endgenerate

    // The RAM returns pre-write data on a same-cycle collision, so capture the write data instead.
    assign fwd_hit_next = (|rd_ack_reg) & ram_write_en_reg & (ram_waddr_reg == ram_raddr_reg);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ack_reg       <= '0;
            rd_ack_reg       <= '0;
            rd_valid_reg     <= '0;
            ram_write_en_reg <= 1'b0;
            ram_waddr_reg    <= '0;
            ram_din_reg      <= '0;
            ram_raddr_reg    <= '0;
            fwd_hit_reg      <= 1'b0;
            fwd_data_reg     <= '0;
        end else begin
            wr_ack_reg       <= wr_ack_next;
            rd_ack_reg       <= rd_ack_next;
            rd_valid_reg     <= rd_ack_reg;
            ram_write_en_reg <= w_grant_valid;
            if (w_grant_valid) begin
                ram_waddr_reg <= waddr_arr[w_grant_idx];
                ram_din_reg   <= wdata_arr[w_grant_idx];
            end
            if (r_grant_valid) begin
                ram_raddr_reg <= raddr_arr[r_grant_idx];
            end
            fwd_hit_reg <= fwd_hit_next;
            if (|rd_ack_reg) begin
                fwd_data_reg <= ram_din_reg;
            end
        end
    end

    assign rdata_mux    = fwd_hit_reg ? fwd_data_reg : ram_dout;

    assign m0_wr_ack    = wr_ack_reg[0];
    assign m1_wr_ack    = wr_ack_reg[1];
    assign m0_rd_ack    = rd_ack_reg[0];
    assign m1_rd_ack    = rd_ack_reg[1];
    assign m0_rd_valid  = rd_valid_reg[0];
    assign m1_rd_valid  = rd_valid_reg[1];
    assign m0_rdata     = rdata_mux;
    assign m1_rdata     = rdata_mux;
    assign ram_waddr    = ram_waddr_reg;
    assign ram_din      = ram_din_reg;
    assign ram_write_en = ram_write_en_reg;
    assign ram_raddr    = ram_raddr_reg;
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// Bench for dual_port_ram_arbiter: RAM model, transaction-level reference model,
// table-driven vectors, hand-written corner sequences and randomized traffic.
module tb_dual_port_ram_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  wr_req = '0;
    logic [1:0]  rd_req = '0;
    logic [4:0]  waddr [2];
    logic [31:0] wdata [2];
    logic [4:0]  raddr [2];
    wire  [1:0]  wr_ack;
    wire  [1:0]  rd_ack;
    wire  [1:0]  rd_valid;
    wire  [31:0] rdata0;
    wire  [31:0] rdata1;
    wire  [4:0]  ram_waddr;
    wire  [31:0] ram_din;
    wire         ram_write_en;
    wire  [4:0]  ram_raddr;
    logic [31:0] ram_dout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dual_port_ram_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .m0_wr_req    (wr_req[0]),
        .m1_wr_req    (wr_req[1]),
        .m0_waddr     (waddr[0]),
        .m1_waddr     (waddr[1]),
        .m0_wdata     (wdata[0]),
        .m1_wdata     (wdata[1]),
        .m0_wr_ack    (wr_ack[0]),
        .m1_wr_ack    (wr_ack[1]),
        .m0_rd_req    (rd_req[0]),
        .m1_rd_req    (rd_req[1]),
        .m0_raddr     (raddr[0]),
        .m1_raddr     (raddr[1]),
        .m0_rd_ack    (rd_ack[0]),
        .m1_rd_ack    (rd_ack[1]),
        .m0_rd_valid  (rd_valid[0]),
        .m1_rd_valid  (rd_valid[1]),
        .m0_rdata     (rdata0),
        .m1_rdata     (rdata1),
        .ram_waddr    (ram_waddr),
        .ram_din      (ram_din),
        .ram_write_en (ram_write_en),
        .ram_raddr    (ram_raddr),
        .ram_dout     (ram_dout)
    );

    // Behaviour of the attached dual_port_ram: registered read, old data on collision.
    logic [31:0] mem [32];
    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        ram_dout = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_write_en) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (transaction level) ----------------
    logic [31:0] gold [32];
    logic [1:0]  m_wack, m_rack, m_rvalid;
    logic [4:0]  m_waddr, m_raddr;
    logic [31:0] m_wdata, m_rdata;
    int          m_wpref, m_rpref;

    function automatic int pick(input logic [1:0] elig, input int pref);
        if (elig == 2'b11) return pref;
        if (elig[0]) return 0;
        if (elig[1]) return 1;
        return -1;
    endfunction

    initial begin
        logic [1:0]  nvalid;
        logic [31:0] nrdata;
        int          w, r;
        for (int i = 0; i < 32; i++) gold[i] = 32'h0;
        m_wack = '0; m_rack = '0; m_rvalid = '0;
        m_waddr = '0; m_raddr = '0; m_wdata = '0; m_rdata = '0;
        m_wpref = 0; m_rpref = 0;
        nrdata = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                m_wack = '0; m_rack = '0; m_rvalid = '0;
                m_wpref = 0; m_rpref = 0;
            end else begin
                check("mdl_wr_ack", 32'(wr_ack), 32'(m_wack));
                check("mdl_rd_ack", 32'(rd_ack), 32'(m_rack));
                check("mdl_rd_valid", 32'(rd_valid), 32'(m_rvalid));
                check("mdl_write_en", 32'(ram_write_en), 32'(m_wack != 2'b00));
                if (m_rvalid[0]) check("mdl_rdata0", rdata0, m_rdata);
                if (m_rvalid[1]) check("mdl_rdata1", rdata1, m_rdata);
                // A write is visible to any read acknowledged in the same cycle or later.
                if (m_wack != 2'b00) begin
                    check("mdl_ram_waddr", 32'(ram_waddr), 32'(m_waddr));
                    check("mdl_ram_din", ram_din, m_wdata);
                    gold[m_waddr] = m_wdata;
                end
                nvalid = m_rack;
                if (m_rack != 2'b00) begin
                    check("mdl_ram_raddr", 32'(ram_raddr), 32'(m_raddr));
                    nrdata = gold[m_raddr];
                end
                w = pick(wr_req & ~m_wack, m_wpref);
                r = pick(rd_req & ~m_rack, m_rpref);
                m_wack = '0;
                m_rack = '0;
                if (w >= 0) begin
                    m_wack[w] = 1'b1;
                    m_waddr   = waddr[w];
                    m_wdata   = wdata[w];
                    m_wpref   = 1 - w;
                end
                if (r >= 0) begin
                    m_rack[r] = 1'b1;
                    m_raddr   = raddr[r];
                    m_rpref   = 1 - r;
                end
                m_rvalid = nvalid;
                if (nvalid != 2'b00) m_rdata = nrdata;
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct packed {
        logic [1:0]  wreq;
        logic [1:0]  rreq;
        logic [4:0]  waddr0;
        logic [4:0]  waddr1;
        logic [4:0]  raddr0;
        logic [4:0]  raddr1;
        logic [31:0] wdata0;
        logic [31:0] wdata1;
        logic [1:0]  exp_wack;
        logic [1:0]  exp_rack;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    task automatic do_write(input int m, input logic [4:0] a, input logic [31:0] d);
        wr_req[m] = 1'b1;
        waddr[m]  = a;
        wdata[m]  = d;
        tick();
        check($sformatf("wr_m%0d_ack", m), 32'(wr_ack), 32'(2'b01 << m));
        wr_req[m] = 1'b0;
        tick();
    endtask

    initial begin
        vec_t        v;
        logic [1:0]  pw, pr;
        waddr[0] = '0; waddr[1] = '0; raddr[0] = '0; raddr[1] = '0;
        wdata[0] = '0; wdata[1] = '0;

        //          wreq   rreq   wa0    wa1    ra0    ra1    wd0           wd1     expW   expR   exp_rdata
        vecs[0] = '{2'b01, 2'b00, 5'd3,  5'd0,  5'd0,  5'd0,  32'hDEADBEEF, 32'h0,  2'b01, 2'b00, 32'h0};
        vecs[1] = '{2'b00, 2'b01, 5'd0,  5'd0,  5'd3,  5'd0,  32'h0,        32'h0,  2'b00, 2'b01, 32'hDEADBEEF};
        vecs[2] = '{2'b11, 2'b00, 5'd1,  5'd2,  5'd0,  5'd0,  32'h11,       32'h22, 2'b10, 2'b00, 32'h0};
        vecs[3] = '{2'b00, 2'b11, 5'd0,  5'd0,  5'd1,  5'd2,  32'h0,        32'h0,  2'b00, 2'b10, 32'h22};
        vecs[4] = '{2'b10, 2'b00, 5'd0,  5'd5,  5'd0,  5'd0,  32'h0,        32'h55, 2'b10, 2'b00, 32'h0};
        vecs[5] = '{2'b11, 2'b00, 5'd8,  5'd9,  5'd0,  5'd0,  32'h88,       32'h99, 2'b01, 2'b00, 32'h0};
        vecs[6] = '{2'b00, 2'b11, 5'd0,  5'd0,  5'd5,  5'd9,  32'h0,        32'h0,  2'b00, 2'b10, 32'h99};
        vecs[7] = '{2'b00, 2'b10, 5'd0,  5'd0,  5'd0,  5'd8,  32'h0,        32'h0,  2'b00, 2'b10, 32'h88};
        vecs[8] = '{2'b00, 2'b11, 5'd0,  5'd0,  5'd1,  5'd2,  32'h0,        32'h0,  2'b00, 2'b01, 32'h11};
        vecs[9] = '{2'b01, 2'b01, 5'd10, 5'd0,  5'd10, 5'd0,  32'hA0,       32'h0,  2'b01, 2'b01, 32'hA0};

        // Reset state
        reset_n = 1'b0;
        tick(); tick(); tick();
        check("rst_wr_ack", 32'(wr_ack), 32'h0);
        check("rst_rd_ack", 32'(rd_ack), 32'h0);
        check("rst_rd_valid", 32'(rd_valid), 32'h0);
        check("rst_write_en", 32'(ram_write_en), 32'h0);
        check("rst_ram_waddr", 32'(ram_waddr), 32'h0);
        check("rst_ram_raddr", 32'(ram_raddr), 32'h0);
        check("rst_ram_din", ram_din, 32'h0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < NVEC; i++) begin
            v = vecs[i];
            wr_req = v.wreq;    rd_req = v.rreq;
            waddr[0] = v.waddr0; waddr[1] = v.waddr1;
            wdata[0] = v.wdata0; wdata[1] = v.wdata1;
            raddr[0] = v.raddr0; raddr[1] = v.raddr1;
            tick();
            check($sformatf("vec%0d_wr_ack", i), 32'(wr_ack), 32'(v.exp_wack));
            check($sformatf("vec%0d_rd_ack", i), 32'(rd_ack), 32'(v.exp_rack));
            wr_req = wr_req & ~wr_ack;
            rd_req = rd_req & ~rd_ack;
            tick();
            check($sformatf("vec%0d_rd_valid", i), 32'(rd_valid), 32'(v.exp_rack));
            if (v.exp_rack[0]) check($sformatf("vec%0d_rdata0", i), rdata0, v.exp_rdata);
            if (v.exp_rack[1]) check($sformatf("vec%0d_rdata1", i), rdata1, v.exp_rdata);
            wr_req = wr_req & ~wr_ack;
            rd_req = rd_req & ~rd_ack;
            tick();
            wr_req = '0; rd_req = '0;
            tick(); tick();
            $display("vec %0d: wreq=%b rreq=%b expW=%b expR=%b rdata=%h", i, v.wreq, v.rreq,
                     v.exp_wack, v.exp_rack, v.exp_rdata);
        end

        // Write-port contention from a fresh reset: m0 first, then strict alternation.
        reset_n = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        wr_req = 2'b11;
        waddr[0] = 5'd1; wdata[0] = 32'h11;
        waddr[1] = 5'd2; wdata[1] = 32'h22;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("wcont%0d_ack", i), 32'(wr_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
            check($sformatf("wcont%0d_we", i), 32'(ram_write_en), 32'h1);
            check($sformatf("wcont%0d_waddr", i), 32'(ram_waddr), (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        wr_req = '0;
        tick(); tick();
        $display("write contention: 8 alternating grants");

        rd_req = 2'b11;
        raddr[0] = 5'd1; raddr[1] = 5'd2;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("rcont%0d_ack", i), 32'(rd_ack), (i % 2 == 0) ? 32'h1 : 32'h2);
            if (i > 0) begin
                check($sformatf("rcont%0d_valid", i), 32'(rd_valid), (i % 2 == 0) ? 32'h2 : 32'h1);
                check($sformatf("rcont%0d_rdata", i), rdata0, (i % 2 == 0) ? 32'h22 : 32'h11);
            end
        end
        rd_req = '0;
        tick(); tick();
        $display("read contention: 8 alternating grants");

        // Forwarding: m1 write and m0 read of the same address acknowledged together.
        do_write(0, 5'd7, 32'h1);
        do_write(0, 5'd6, 32'h66);
        wr_req[1] = 1'b1; waddr[1] = 5'd7; wdata[1] = 32'hA5;
        rd_req[0] = 1'b1; raddr[0] = 5'd7;
        tick();
        check("fwd_wr_ack", 32'(wr_ack), 32'h2);
        check("fwd_rd_ack", 32'(rd_ack), 32'h1);
        wr_req = '0; rd_req = '0;
        tick();
        check("fwd_rd_valid", 32'(rd_valid), 32'h1);
        check("fwd_rdata0", rdata0, 32'hA5);
        check("fwd_rdata1", rdata1, 32'hA5);
        tick();
        $display("forward hit: addr 7 -> %h", 32'hA5);

        wr_req[1] = 1'b1; waddr[1] = 5'd7; wdata[1] = 32'h5A;
        rd_req[0] = 1'b1; raddr[0] = 5'd6;
        tick();
        check("nofwd_rd_ack", 32'(rd_ack), 32'h1);
        wr_req = '0; rd_req = '0;
        tick();
        check("nofwd_rd_valid", 32'(rd_valid), 32'h1);
        check("nofwd_rdata0", rdata0, 32'h66);
        tick();
        $display("forward miss: addr 6 -> %h", 32'h66);

        // Reset during the rd_ack cycle; last write grant was m0, so a surviving pointer would favour m1.
        do_write(0, 5'd13, 32'h1313);
        rd_req[0] = 1'b1; raddr[0] = 5'd3;
        tick();
        check("rstmid_rd_ack", 32'(rd_ack), 32'h1);
        reset_n = 1'b0;
        rd_req = '0;
        #1;
        check("rstmid_rd_ack0", 32'(rd_ack), 32'h0);
        check("rstmid_wr_ack0", 32'(wr_ack), 32'h0);
        check("rstmid_we0", 32'(ram_write_en), 32'h0);
        check("rstmid_waddr0", 32'(ram_waddr), 32'h0);
        check("rstmid_raddr0", 32'(ram_raddr), 32'h0);
        check("rstmid_din0", ram_din, 32'h0);
        tick();
        check("rstmid_no_valid", 32'(rd_valid), 32'h0);
        tick();
        reset_n = 1'b1;
        wr_req = 2'b11;
        waddr[0] = 5'd4; wdata[0] = 32'h44;
        waddr[1] = 5'd9; wdata[1] = 32'h99;
        tick();
        check("rstmid_tie_first", 32'(wr_ack), 32'h1);
        wr_req[0] = 1'b0;
        tick();
        check("rstmid_tie_second", 32'(wr_ack), 32'h2);
        wr_req = '0;
        rd_req[1] = 1'b1; raddr[1] = 5'd11;
        tick();
        check("rstmid_rd_m1", 32'(rd_ack), 32'h2);
        rd_req = '0;
        tick();
        $display("reset mid-op: valid dropped, m0 wins first tie");

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("idle%0d_we", i), 32'(ram_write_en), 32'h0);
            check($sformatf("idle%0d_acks", i), 32'({wr_ack, rd_ack, rd_valid}), 32'h0);
            check($sformatf("idle%0d_waddr", i), 32'(ram_waddr), 32'd9);
            check($sformatf("idle%0d_raddr", i), 32'(ram_raddr), 32'd11);
            check($sformatf("idle%0d_din", i), ram_din, 32'h99);
        end
        $display("idle hold: 10 cycles");

        // Randomized traffic; requesters change req the cycle after their ack.
        pw = '0; pr = '0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (c == 700) begin
                reset_n = 1'b0;
                wr_req = '0; rd_req = '0;
                pw = '0; pr = '0;
                tick(); tick();
                reset_n = 1'b1;
            end
            for (int m = 0; m < 2; m++) begin
                if (pw[m]) wr_req[m] = 1'b0;
                if (pr[m]) rd_req[m] = 1'b0;
                if (!wr_req[m] && $urandom_range(0, 1) == 0) begin
                    wr_req[m] = 1'b1;
                    waddr[m]  = 5'($urandom_range(0, 7));
                    wdata[m]  = $urandom;
                end
                if (!rd_req[m] && $urandom_range(0, 1) == 0) begin
                    rd_req[m] = 1'b1;
                    raddr[m]  = 5'($urandom_range(0, 7));
                end
            end
            pw = wr_ack;
            pr = rd_ack;
        end
        wr_req = '0; rd_req = '0;
        tick(); tick(); tick(); tick();
        $display("random traffic: 1500 cycles");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
